// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: request/response handshakes and data-memory port 1 bus of the LSU initiator
// Signal groups (modport master = initiator side, slave = core/memory environment side):
//   req_valid/req_ready, req_write, req_type, req_addr, req_wdata : load/store request
//   resp_valid/resp_ready, resp_rdata, resp_error                : response
//   MemReadEn, MemWriteEn, loadtype, storetype, AddressBus,
//   DataMemoryInput                                              : drive to memory
//   DataMemoryOutput                                             : registered read data from memory
interface lsu_mem_initiator_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [3:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_error;
    logic              MemReadEn;
    logic              MemWriteEn;
    logic [3:0]        loadtype;
    logic [3:0]        storetype;
    logic [ADDR_W-1:0] AddressBus;
    logic [DATA_W-1:0] DataMemoryInput;
    logic [DATA_W-1:0] DataMemoryOutput;

    modport master (
        input  req_valid, req_write, req_type, req_addr, req_wdata, resp_ready, DataMemoryOutput,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output MemReadEn, MemWriteEn, loadtype, storetype, AddressBus, DataMemoryInput
    );

    modport slave (
        output req_valid, req_write, req_type, req_addr, req_wdata, resp_ready, DataMemoryOutput,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  MemReadEn, MemWriteEn, loadtype, storetype, AddressBus, DataMemoryInput
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: one-at-a-time load/store initiator between the memory stage and data-memory port 1
// Ports:
//   clock : single clock, posedge
//   rst   : asynchronous active-low reset
//   bus   : lsu_mem_initiator_if.master (request, response and memory-side signals)
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject accesses whose address is not a
// multiple of the access size (error response, no memory access).
`ifndef LSU_DEFS_SVH
`define LSU_DEFS_SVH
`define BIT_WIDTH              64
`define MEMORY_BITS            8
`define LOAD_BYTE              4'd0
`define LOAD_HALFWORD          4'd1
`define LOAD_WORD              4'd2
`define LOAD_DOUBLEWORD        4'd3
`define LOAD_BYTE_UNSIGNED     4'd4
`define LOAD_HALFWORD_UNSIGNED 4'd5
`define LOAD_WORD_UNSIGNED     4'd6
`define STORE_BYTE             4'd0
`define STORE_HALFWORD         4'd1
`define STORE_WORD             4'd2
`define STORE_DOUBLEWORD       4'd3
`endif

module lsu_mem_initiator #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = `BIT_WIDTH
) (
    input logic               clock,
    input logic               rst,
    lsu_mem_initiator_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [3:0]        type_q, type_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;
    logic              legal, misaligned, illegal;
    logic              issue, read_en, write_en;

    always_comb begin
        legal = bus.req_write
            ? bus.req_type inside {`STORE_BYTE, `STORE_HALFWORD, `STORE_WORD, `STORE_DOUBLEWORD}
            : bus.req_type inside {`LOAD_BYTE, `LOAD_HALFWORD, `LOAD_WORD, `LOAD_DOUBLEWORD,
                                   `LOAD_BYTE_UNSIGNED, `LOAD_HALFWORD_UNSIGNED, `LOAD_WORD_UNSIGNED};
        illegal = !legal || misaligned;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [2:0] size_mask;
    always_comb begin
        size_mask = bus.req_write
            ? (bus.req_type == `STORE_DOUBLEWORD ? 3'd7 :
               bus.req_type == `STORE_WORD       ? 3'd3 :
               bus.req_type == `STORE_HALFWORD   ? 3'd1 : 3'd0)
            : (bus.req_type == `LOAD_DOUBLEWORD                                    ? 3'd7 :
               bus.req_type inside {`LOAD_WORD, `LOAD_WORD_UNSIGNED}                ? 3'd3 :
               bus.req_type inside {`LOAD_HALFWORD, `LOAD_HALFWORD_UNSIGNED}        ? 3'd1 : 3'd0);
        misaligned = |(bus.req_addr[2:0] & size_mask);
    end
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                write_d = bus.req_write;
                type_d  = bus.req_type;
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                error_d = illegal;
                state_d = illegal ? RESP : ISSUE;
            end
            ISSUE: state_d = write_q ? RESP : CAPTURE;
            CAPTURE: begin
                rdata_d = bus.DataMemoryOutput;
                state_d = RESP;
            end
            RESP: if (bus.resp_ready) begin
                rdata_d = '0;
                error_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side lines are gated to zero outside ISSUE so the memory sees an idle bus.
    always_comb begin
        issue               = state_q == ISSUE;
        read_en             = issue && !write_q;
        write_en            = issue && write_q;
        bus.req_ready       = state_q == IDLE;
        bus.resp_valid      = state_q == RESP;
        bus.resp_rdata      = rdata_q;
        bus.resp_error      = error_q;
        bus.MemReadEn       = read_en;
        bus.MemWriteEn      = write_en;
        bus.loadtype        = read_en ? type_q : 4'd0;
        bus.storetype       = write_en ? type_q : 4'd0;
        bus.AddressBus      = issue ? addr_q : '0;
        bus.DataMemoryInput = write_en ? wdata_q : '0;
    end
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb_lsu_mem_initiator: table-driven, scoreboarded bench for lsu_mem_initiator with a byte memory model
module tb_lsu_mem_initiator;
    localparam logic [3:0] LB = 4'd0, LH = 4'd1, LW = 4'd2, LD = 4'd3, LBU = 4'd4, LHU = 4'd5, LWU = 4'd6;
    localparam logic [3:0] SB = 4'd0, SH = 4'd1, SW = 4'd2, SD = 4'd3;

    typedef struct {
        logic        write;
        logic [3:0]  typ;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic        write;
        logic [3:0]  typ;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic        err;
        int          en;
    } exp_t;

    logic clock = 1'b0;
    logic rst = 1'b0;
    always #5 clock = ~clock;

    lsu_mem_initiator_if #(.ADDR_W(64), .DATA_W(64)) bus ();
    lsu_mem_initiator #(.ADDR_W(64), .DATA_W(64)) dut (.clock(clock), .rst(rst), .bus(bus.master));

    int   n_vec = 0;
    int   n_bad = 0;
    int   en_cnt = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Byte-addressed memory with registered, sign/zero-extended read data that idles at 0.
    logic [7:0]  mem [256];
    logic [63:0] dout = 64'h0;
    assign bus.DataMemoryOutput = dout;

    function automatic logic [63:0] load_val(input logic [7:0] a, input logic [3:0] t);
        logic [63:0] raw;
        int          n;
        logic        s;
        for (int i = 0; i < 8; i++) raw[8*i +: 8] = mem[a + 8'(i)];
        n = 8 << t[1:0];
        s = raw[n-1] && !t[2];
        for (int i = 0; i < 64; i++) if (i >= n) raw[i] = s;
        return raw;
    endfunction

    always @(posedge clock) begin
        if (bus.MemWriteEn)
            for (int i = 0; i < 8; i++)
                if (i < (1 << bus.storetype[1:0])) mem[bus.AddressBus[7:0] + 8'(i)] <= bus.DataMemoryInput[8*i +: 8];
        dout <= bus.MemReadEn ? load_val(bus.AddressBus[7:0], bus.loadtype) : 64'h0;
    end

    // Monitor: checks memory-side activity against the head of the scoreboard and pops on handshake.
    always @(negedge clock) begin
        if (!rst) en_cnt = 0;
        else begin
            if (bus.MemReadEn || bus.MemWriteEn) begin
                en_cnt++;
                if (exp_q.size() != 0) begin
                    chk("issue_write", 64'(bus.MemWriteEn), 64'(exp_q[0].write));
                    chk("issue_addr", bus.AddressBus, exp_q[0].addr);
                    chk("issue_type", 64'(bus.MemWriteEn ? bus.storetype : bus.loadtype), 64'(exp_q[0].typ));
                    if (bus.MemWriteEn) chk("issue_wdata", bus.DataMemoryInput, exp_q[0].wdata);
                end
            end else
                chk("mem_idle_zero", bus.AddressBus | bus.DataMemoryInput | 64'(bus.loadtype) | 64'(bus.storetype), 64'h0);
            if (bus.resp_valid && bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_resp: got rdata %h error %b expected no response", bus.resp_rdata, bus.resp_error);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_rdata", bus.resp_rdata, mon_e.rdata);
                    chk("resp_error", 64'(bus.resp_error), 64'(mon_e.err));
                    chk("mem_enables", 64'(en_cnt), 64'(mon_e.en));
                end
                en_cnt = 0;
            end
        end
    end

    task automatic issue(input vec_t v, input string name);
        int   w = 0;
        exp_t x;
        while (!bus.req_ready && w < 20) begin @(posedge clock); #1; w++; end
        chk({name, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.req_write = v.write;
        bus.req_type  = v.typ;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        x.write = v.write;
        x.typ   = v.typ;
        x.addr  = v.addr;
        x.wdata = v.wdata;
        x.rdata = v.rdata;
        x.err   = v.err;
        x.en    = v.err ? 0 : 1;
        @(posedge clock);
        exp_q.push_back(x);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int w = 0;
        issue(v, name);
        while (!bus.resp_valid && w < 10) begin @(posedge clock); #1; w++; end
        chk({name, "_latency"}, 64'(w), 64'(v.lat));
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin @(posedge clock); #1; w++; end
        chk({name, "_consumed"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   w;
        for (int i = 0; i < 256; i++) mem[i] = 8'h0;
        vecs[0]  = '{1'b1, SD,    64'h10, 64'h8877665544332211, 64'h0, 1'b0, 1};
        vecs[1]  = '{1'b0, LD,    64'h10, 64'h0, 64'h8877665544332211, 1'b0, 2};
        vecs[2]  = '{1'b1, SB,    64'h20, 64'hAAAAAAAAAAAAAA80, 64'h0, 1'b0, 1};
        vecs[3]  = '{1'b0, LB,    64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2};
        vecs[4]  = '{1'b0, LBU,   64'h20, 64'h0, 64'h0000000000000080, 1'b0, 2};
        vecs[5]  = '{1'b0, LD,    64'h20, 64'h0, 64'h0000000000000080, 1'b0, 2};
        vecs[6]  = '{1'b0, 4'hF,  64'h10, 64'h0, 64'h0, 1'b1, 0};
        vecs[7]  = '{1'b1, 4'h7,  64'h10, 64'h5555, 64'h0, 1'b1, 0};
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[8]  = '{1'b0, LW,    64'h13, 64'h0, 64'h0, 1'b1, 0};
        vecs[16] = '{1'b1, SD,    64'h44, 64'h1, 64'h0, 1'b1, 0};
`else
        vecs[8]  = '{1'b0, LW,    64'h13, 64'h0, 64'h0000000077665544, 1'b0, 2};
        vecs[16] = '{1'b1, SD,    64'h44, 64'h1, 64'h0, 1'b0, 1};
`endif
        vecs[9]  = '{1'b1, SH,    64'h30, 64'h000000001234BEEF, 64'h0, 1'b0, 1};
        vecs[10] = '{1'b0, LHU,   64'h30, 64'h0, 64'h000000000000BEEF, 1'b0, 2};
        vecs[11] = '{1'b0, LH,    64'h30, 64'h0, 64'hFFFFFFFFFFFFBEEF, 1'b0, 2};
        vecs[12] = '{1'b0, LWU,   64'h14, 64'h0, 64'h0000000088776655, 1'b0, 2};
        vecs[13] = '{1'b0, LW,    64'h14, 64'h0, 64'hFFFFFFFF88776655, 1'b0, 2};
        vecs[14] = '{1'b1, SW,    64'h40, 64'hDEADBEEF12345678, 64'h0, 1'b0, 1};
        vecs[15] = '{1'b0, LD,    64'h40, 64'h0, 64'h0000000012345678, 1'b0, 2};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_type   = 4'h0;
        bus.req_addr   = 64'h0;
        bus.req_wdata  = 64'h0;
        bus.resp_ready = 1'b1;

        #3;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_error", 64'(bus.resp_error), 64'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 64'h0);
        chk("rst_enables", 64'({bus.MemReadEn, bus.MemWriteEn}), 64'd0);
        chk("rst_mem_bus", bus.AddressBus | bus.DataMemoryInput | 64'({bus.loadtype, bus.storetype}), 64'h0);
        @(posedge clock);
        @(posedge clock);
        #1;
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

        for (int i = 0; i < 17; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Backpressure: response must hold while resp_ready is low, and no new request is taken.
        bus.resp_ready = 1'b0;
        v = '{1'b0, LD, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 2};
        issue(v, "bp");
        w = 0;
        while (!bus.resp_valid && w < 10) begin @(posedge clock); #1; w++; end
        chk("bp_latency", 64'(w), 64'd2);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_type  = LB;
        bus.req_addr  = 64'h20;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            chk("bp_resp_rdata", bus.resp_rdata, 64'h8877665544332211);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        w = 0;
        while (exp_q.size() != 0 && w < 20) begin @(posedge clock); #1; w++; end
        chk("bp_consumed", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
        chk("bp_idle_valid", 64'(bus.resp_valid), 64'd0);
        chk("bp_idle_ready", 64'(bus.req_ready), 64'd1);

        // Reset during CAPTURE drops the pending load.
        v = '{1'b0, LD, 64'h10, 64'h0, 64'h8877665544332211, 1'b0, 2};
        issue(v, "rstmid");
        @(posedge clock);
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rstmid_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rstmid_resp_rdata", bus.resp_rdata, 64'h0);
        chk("rstmid_enables", 64'({bus.MemReadEn, bus.MemWriteEn}), 64'd0);
        chk("rstmid_mem_bus", bus.AddressBus | bus.DataMemoryInput, 64'h0);
        exp_q.delete();
        #4;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
            chk("rstmid_no_resp", 64'(bus.resp_valid), 64'd0);
            chk("rstmid_ready", 64'(bus.req_ready), 64'd1);
        end

        run_vec(vecs[1], "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator that sits between the core's memory stage and port 1 of the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's read/write enables, type, address and write-data lines for exactly one cycle. For loads it captures the registered read data and returns a single response over a second valid/ready handshake. Stores are acknowledged the same way, with zero data.

## Interface
Parameters:
- `ADDR_W`, 64: width of request and memory address.
- `DATA_W`, 64: width of data paths; must match `` `BIT_WIDTH ``.

Ports:
- `clock`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_type`  in  4  `` `LOAD_* `` code when loading, `` `STORE_* `` code when storing (defs.h encodings).
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  DATA_W  store data, little-endian, low bytes used.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  DATA_W  load result as returned by memory; 0 for stores and errors.
- `resp_error`  out  1  request rejected without memory access.
- `MemReadEn`  out  1  memory read enable.
- `MemWriteEn`  out  1  memory write enable.
- `loadtype`  out  4  to memory.
- `storetype`  out  4  to memory.
- `AddressBus`  out  ADDR_W  to memory.
- `DataMemoryInput`  out  DATA_W  to memory.
- `DataMemoryOutput`  in  DATA_W  registered read data from memory.

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch write, type, addr and wdata.
  - If the request is illegal, go to RESP with `resp_error`=1. Otherwise go to ISSUE.
- Illegal request: type not among the defined load codes (load) or the defined store codes (store).
- ISSUE:
  - Drive the latched address onto `AddressBus`.
  - Load: `MemReadEn`=1, `loadtype`=latched type.
  - Store: `MemWriteEn`=1, `storetype`=latched type, `DataMemoryInput`=latched wdata.
  - Next state is CAPTURE for a load, RESP for a store.
- CAPTURE: enables low; register `DataMemoryOutput` into `resp_rdata`; go to RESP.
- RESP: `resp_valid`=1. On `resp_ready`, clear `resp_rdata` and `resp_error`, then go to IDLE.
- Memory-side outputs are all zero in every state except ISSUE, so the memory's read output returns to 0 between accesses.
- No sign/zero extension inside this block; the memory performs it.
- Addresses are passed through unmodified; the memory truncates to `` `MEMORY_BITS ``.

## Timing
- Reset (`rst`=0, asynchronous):
  - State forced to IDLE.
  - `req_ready`=1, `resp_valid`=0, `resp_error`=0, `resp_rdata`=0.
  - All memory-side outputs 0.
- Reset mid-operation: the pending request is dropped. If asserted during ISSUE, the enables fall immediately and the write is not guaranteed.
- Load latency, with acceptance at edge N:
  - ISSUE in cycle N..N+1.
  - Memory samples at edge N+1.
  - CAPTURE samples data at edge N+2.
  - `resp_valid` high from edge N+2.
  - Best-case throughput: one load per 4 cycles.
- Store latency: `resp_valid` high from edge N+1 (memory writes at that edge); one store per 3 cycles.
- Error response: `resp_valid` high from edge N.
- The response is held stable while `resp_valid` is high and `resp_ready` is low; the block does not accept a new request meanwhile.
- A request presented with `resp_ready` high during RESP is not accepted in that cycle: `req_ready` is low until IDLE.

## Configuration
- `LSU_MISALIGN_TRAP_EN`:
  - Defined: a request whose address is not a multiple of its access size is illegal. Sizes: halfword 2, word 4, doubleword 8. It gets an error response with no memory access.
  - Undefined: misaligned accesses are issued to memory unchanged, and the memory handles the byte lanes naturally.

## Test plan
- Store then load:
  - Store `` `STORE_DOUBLEWORD `` at addr 0x10, data 0x8877665544332211 -> `resp_valid` 1 cycle after acceptance, `resp_rdata`=0.
  - Then `` `LOAD_DOUBLEWORD `` at 0x10 -> `resp_rdata`=0x8877665544332211 two cycles after acceptance.
- Sign/zero extension: byte 0x80 stored at 0x20.
  - `` `LOAD_BYTE `` -> 0xFFFFFFFFFFFFFF80.
  - `` `LOAD_BYTE_UNSIGNED `` -> 0x0000000000000080.
- Backpressure: hold `resp_ready`=0 for 5 cycles after a load response -> `resp_valid`, `resp_rdata` stable and `req_ready`=0 throughout; exactly one response consumed.
- Illegal type: load with `req_type`=0xF -> `resp_error`=1 on the following edge, and `MemReadEn`/`MemWriteEn` never asserted.
- Misalignment: `` `LOAD_WORD `` at 0x13.
  - With `LSU_MISALIGN_TRAP_EN`: error response, no memory enable.
  - Without it: memory read issued, bytes 0x13..0x16 returned.
- Reset mid-load: drop `rst` during CAPTURE -> all outputs 0 immediately, `req_ready`=1 after release, no spurious `resp_valid`.
